// File: rtl/io_dispatch.sv
// -----------------------------------------------------------------------------
// io_dispatch
// Host-to-core dispatcher. Accepts host words over a ready/next handshake and
// loads them block-by-block into CH channel buffers (ascending order, masked
// channels skipped), then starts all enabled channels and waits until every
// enabled channel has reported done. Fully registered outputs.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   int_req, process      session request / run-without-load select (IDLE only)
//   ch_en[CH]             channel enable mask, captured at session start
//   data[DATA_W], ready, eob   host word, valid, last-of-block marker
//   next                  one-cycle accept pulse
//   out_data, out_addr    registered accepted word and its block index
//   out_we[CH]            one-hot channel buffer write strobe
//   start[CH]             per-channel run request (level)
//   done[CH]              per-channel completion pulse
//   busy, err             not-idle flag, sticky block-overflow flag
// -----------------------------------------------------------------------------
module io_dispatch #(
    parameter int CH     = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              int_req,
    input  logic              process,
    input  logic [CH-1:0]     ch_en,
    input  logic [DATA_W-1:0] data,
    input  logic              ready,
    input  logic              eob,
    output logic              next,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_addr,
    output logic [CH-1:0]     out_we,
    output logic [CH-1:0]     start,
    input  logic [CH-1:0]     done,
    output logic              busy,
    output logic              err
);

    localparam int PTR_W = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Index of the lowest set bit of a mask (0 when the mask is empty).
    function automatic logic [PTR_W-1:0] f_lowest(input logic [CH-1:0] m);
        logic [PTR_W-1:0] idx;
        idx = {PTR_W{1'b0}};
        for (int c = CH - 1; c >= 0; c--) begin
            if (m[c]) idx = PTR_W'(c);
        end
        return idx;
    endfunction

    // Mask with every bit at or below the pointer cleared.
    function automatic logic [CH-1:0] f_above(input logic [CH-1:0] m, input logic [PTR_W-1:0] p);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) begin
            r[c] = m[c] && (c > int'(p));
        end
        return r;
    endfunction

    // One-hot decode of a channel pointer.
    function automatic logic [CH-1:0] f_onehot(input logic [PTR_W-1:0] p);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) begin
            r[c] = (p == PTR_W'(c));
        end
        return r;
    endfunction

    logic [1:0]        r_state;
    logic              r_next;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_out_addr;
    logic [CH-1:0]     r_out_we;
    logic [CH-1:0]     r_start;
    logic              r_busy;
    logic              r_err;
    logic [CH-1:0]     r_en_q;
    logic [CH-1:0]     r_fin;
    logic [PTR_W-1:0]  r_ch_ptr;
    logic [CNT_W-1:0]  r_addr;
    // Set once the last address of the block has been written; any further
    // non-eob word for this channel is an overflow.
    logic              r_full;

    logic [1:0]        w_state_n;
    logic              w_next_n;
    logic [DATA_W-1:0] w_data_n;
    logic [CNT_W-1:0]  w_oaddr_n;
    logic [CH-1:0]     w_we_n;
    logic              w_err_n;
    logic [CH-1:0]     w_en_n;
    logic [CH-1:0]     w_fin_n;
    logic [PTR_W-1:0]  w_ptr_n;
    logic [CNT_W-1:0]  w_addr_n;
    logic              w_full_n;
    logic [CH-1:0]     w_above;

    assign w_above = f_above(r_en_q, r_ch_ptr);

    // Next-state and next-output computation for the dispatcher FSM.
    always_comb begin
        w_state_n = r_state;
        w_next_n  = 1'b0;
        w_data_n  = r_out_data;
        w_oaddr_n = r_out_addr;
        w_we_n    = {CH{1'b0}};
        w_err_n   = r_err;
        w_en_n    = r_en_q;
        w_fin_n   = r_fin;
        w_ptr_n   = r_ch_ptr;
        w_addr_n  = r_addr;
        w_full_n  = r_full;
        case (r_state)
            ST_IDLE: begin
                if (int_req && (ch_en != {CH{1'b0}})) begin
                    w_en_n   = ch_en;
                    w_fin_n  = {CH{1'b0}};
                    w_err_n  = 1'b0;
                    w_addr_n = {CNT_W{1'b0}};
                    w_full_n = 1'b0;
                    if (!process) begin
                        w_state_n = ST_LOAD;
                        w_ptr_n   = f_lowest(ch_en);
                    end else begin
                        w_state_n = ST_RUN;
                    end
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // r_next blocks a second accept on the word just taken.
                if (ready && !r_next) begin
                    w_next_n  = 1'b1;
                    w_data_n  = data;
                    w_oaddr_n = r_addr;
                    if (r_full) begin
                        w_we_n = {CH{1'b0}};
                    end else begin
                        w_we_n = f_onehot(r_ch_ptr);
                    end
                    if (eob) begin
                        w_addr_n = {CNT_W{1'b0}};
                        w_full_n = 1'b0;
                        if (w_above != {CH{1'b0}}) begin
                            w_ptr_n = f_lowest(w_above);
                        end else begin
                            w_state_n = ST_RUN;
                        end
                    end else if (r_full) begin
                        w_err_n = 1'b1;
                    end else if (r_addr == {CNT_W{1'b1}}) begin
                        w_full_n = 1'b1;
                    end else begin
                        w_addr_n = r_addr + CNT_W'(1'b1);
                    end
                end else begin
                    w_next_n = 1'b0;
                end
            end
            ST_RUN: begin
                w_fin_n = r_fin | (done & r_en_q);
                if (w_fin_n == r_en_q) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_state_n = ST_RUN;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; start/busy are registered from next-state
    // values so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_next     <= 1'b0;
            r_out_data <= {DATA_W{1'b0}};
            r_out_addr <= {CNT_W{1'b0}};
            r_out_we   <= {CH{1'b0}};
            r_start    <= {CH{1'b0}};
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_en_q     <= {CH{1'b0}};
            r_fin      <= {CH{1'b0}};
            r_ch_ptr   <= {PTR_W{1'b0}};
            r_addr     <= {CNT_W{1'b0}};
            r_full     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_next     <= w_next_n;
            r_out_data <= w_data_n;
            r_out_addr <= w_oaddr_n;
            r_out_we   <= w_we_n;
            r_start    <= w_en_n & ~w_fin_n & {CH{(w_state_n == ST_RUN)}};
            r_busy     <= (w_state_n != ST_IDLE);
            r_err      <= w_err_n;
            r_en_q     <= w_en_n;
            r_fin      <= w_fin_n;
            r_ch_ptr   <= w_ptr_n;
            r_addr     <= w_addr_n;
            r_full     <= w_full_n;
        end
    end

    assign next     = r_next;
    assign out_data = r_out_data;
    assign out_addr = r_out_addr;
    assign out_we   = r_out_we;
    assign start    = r_start;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_io_dispatch.sv
// -----------------------------------------------------------------------------
// tb_io_dispatch
// Directed bench for io_dispatch (CH=4, DATA_W=32, CNT_W=2) with hand-computed
// expected values. Inputs change #1 after the rising edge; outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_io_dispatch;

    logic        clk;
    logic        reset_n;
    logic        int_req;
    logic        process;
    logic [3:0]  ch_en;
    logic [31:0] data;
    logic        ready;
    logic        eob;
    logic        next;
    logic [31:0] out_data;
    logic [1:0]  out_addr;
    logic [3:0]  out_we;
    logic [3:0]  start;
    logic [3:0]  done;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    io_dispatch #(.CH(4), .DATA_W(32), .CNT_W(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .int_req  (int_req),
        .process  (process),
        .ch_en    (ch_en),
        .data     (data),
        .ready    (ready),
        .eob      (eob),
        .next     (next),
        .out_data (out_data),
        .out_addr (out_addr),
        .out_we   (out_we),
        .start    (start),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [3:0] en, input logic proc);
        int_req = 1'b1;
        ch_en   = en;
        process = proc;
        step();
        int_req = 1'b0;
        ch_en   = 4'b0000;
        process = 1'b0;
        check("sess_busy", {63'd0, busy}, 64'd1);
    endtask

    // Present one word and wait (bounded) for its accept pulse.
    task automatic send_word(input logic [31:0] d, input logic e,
                             input logic [3:0] exp_we, input logic [1:0] exp_addr);
        bit got;
        got   = 1'b0;
        data  = d;
        eob   = e;
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (next) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_seen", {63'd0, got}, 64'd1);
        check("out_data", {32'd0, out_data}, {32'd0, d});
        check("out_addr", {62'd0, out_addr}, {62'd0, exp_addr});
        check("out_we", {60'd0, out_we}, {60'd0, exp_we});
        ready = 1'b0;
        eob   = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] d);
        done = d;
        step();
        done = 4'b0000;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_next"}, {63'd0, next}, 64'd0);
        check({tag, "_we"}, {60'd0, out_we}, 64'd0);
        check({tag, "_start"}, {60'd0, start}, 64'd0);
        check({tag, "_data"}, {32'd0, out_data}, 64'd0);
        check({tag, "_addr"}, {62'd0, out_addr}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        int_req = 1'b0;
        process = 1'b0;
        ch_en   = 4'b0000;
        data    = 32'd0;
        ready   = 1'b0;
        eob     = 1'b0;
        done    = 4'b0000;
        #12;
        check_idle_outputs("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        // Full mask, two words per channel.
        start_session(4'b1111, 1'b0);
        for (int c = 0; c < 4; c++) begin
            logic [3:0] we;
            we = 4'b0001 << c;
            send_word(32'hA000_0000 + 32'(2 * c), 1'b0, we, 2'd0);
            send_word(32'hA000_0000 + 32'(2 * c + 1), 1'b1, we, 2'd1);
            if (c < 3) check("t1_start_load", {60'd0, start}, 64'd0);
        end
        check("t1_start_run", {60'd0, start}, 64'hF);
        pulse_done(4'b0001);
        check("t1_start_d0", {60'd0, start}, 64'hE);
        pulse_done(4'b0010);
        check("t1_start_d1", {60'd0, start}, 64'hC);
        pulse_done(4'b0100);
        check("t1_start_d2", {60'd0, start}, 64'h8);
        check("t1_busy_d2", {63'd0, busy}, 64'd1);
        pulse_done(4'b1000);
        check("t1_busy_end", {63'd0, busy}, 64'd0);
        check("t1_start_end", {60'd0, start}, 64'd0);

        // Skip mask.
        start_session(4'b1010, 1'b0);
        send_word(32'hB000_0001, 1'b1, 4'b0010, 2'd0);
        send_word(32'hB000_0003, 1'b1, 4'b1000, 2'd0);
        check("t2_start", {60'd0, start}, 64'hA);
        pulse_done(4'b0001);
        check("t2_start_ign", {60'd0, start}, 64'hA);
        check("t2_busy_ign", {63'd0, busy}, 64'd1);
        pulse_done(4'b1010);
        check("t2_busy_end", {63'd0, busy}, 64'd0);

        // Block overflow on channel 0.
        start_session(4'b0001, 1'b0);
        send_word(32'hC000_0000, 1'b0, 4'b0001, 2'd0);
        send_word(32'hC000_0001, 1'b0, 4'b0001, 2'd1);
        send_word(32'hC000_0002, 1'b0, 4'b0001, 2'd2);
        send_word(32'hC000_0003, 1'b0, 4'b0001, 2'd3);
        check("t3_err_pre", {63'd0, err}, 64'd0);
        send_word(32'hC000_0004, 1'b0, 4'b0000, 2'd3);
        check("t3_err_set", {63'd0, err}, 64'd1);
        send_word(32'hC000_0005, 1'b1, 4'b0000, 2'd3);
        check("t3_start", {60'd0, start}, 64'h1);
        pulse_done(4'b0001);
        check("t3_busy_end", {63'd0, busy}, 64'd0);
        step();
        check("t3_err_sticky", {63'd0, err}, 64'd1);

        // Run without load; also clears err.
        start_session(4'b0110, 1'b1);
        check("t5_err_clr", {63'd0, err}, 64'd0);
        check("t5_start", {60'd0, start}, 64'h6);
        check("t5_next", {63'd0, next}, 64'd0);
        pulse_done(4'b0110);
        check("t5_busy_end", {63'd0, busy}, 64'd0);
        check("t5_start_end", {60'd0, start}, 64'd0);

        // Ready held for 5 cycles on one word.
        start_session(4'b0001, 1'b0);
        data  = 32'hD000_0000;
        eob   = 1'b0;
        ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t4_next", {63'd0, next}, {63'd0, (k % 2) == 1});
            if ((k % 2) == 1) begin
                check("t4_addr", {62'd0, out_addr}, 64'((k - 1) / 2));
                check("t4_we", {60'd0, out_we}, 64'h1);
            end else begin
                check("t4_we_gap", {60'd0, out_we}, 64'h0);
            end
        end
        ready = 1'b0;
        step();
        check("t4_next_drop", {63'd0, next}, 64'd0);
        send_word(32'hD000_0001, 1'b1, 4'b0001, 2'd3);
        pulse_done(4'b0001);
        check("t4_busy_end", {63'd0, busy}, 64'd0);

        // Reset in the middle of a load, then an empty-mask request.
        start_session(4'b1111, 1'b0);
        send_word(32'hE000_0000, 1'b0, 4'b0001, 2'd0);
        send_word(32'hE000_0001, 1'b0, 4'b0001, 2'd1);
        send_word(32'hE000_0002, 1'b0, 4'b0001, 2'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        int_req = 1'b1;
        ch_en   = 4'b0000;
        step();
        int_req = 1'b0;
        check_idle_outputs("t6_empty");
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("t6_busy_late", {63'd0, busy}, 64'd0);
        check("t6_next_late", {63'd0, next}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_dispatch.md
# io_dispatch

Parametrised host-to-core dispatcher. Accepts a stream of DATA_W-bit words from the host over a ready/next handshake and loads them block-by-block into CH compute-channel buffers, selecting channels in ascending order and skipping those masked off. It then starts all enabled channels and tracks per-channel completion. Sits between the host IO bus and the channel compute cores; it replaces the fixed 4-lane latch-based IO FSM with a fully registered design.

## Interface

- CH, 4, number of compute channels (1..16)
- DATA_W, 32, host word width
- CNT_W, 8, word-address width; max block length 2^CNT_W words
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- int_req  in  1  host session request, sampled in IDLE only
- process  in  1  sampled with int_req: 0 = load then run, 1 = run without load
- ch_en  in  CH  channel enable mask, captured into en_q at session start
- data  in  DATA_W  host word
- ready  in  1  data/eob valid; held by host until next is seen
- eob  in  1  current word is the last of the current channel's block
- next  out  1  one-cycle accept pulse
- out_data  out  DATA_W  registered accepted word
- out_addr  out  CNT_W  word index within the current channel block
- out_we  out  CH  one-hot write strobe to the channel buffer, one cycle
- start  out  CH  level: run request per channel
- done  in  CH  one-cycle completion pulse from each core
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky block-overflow flag

## Operation

- States: IDLE, LOAD, RUN.
- IDLE: if int_req=1 and ch_en!=0, capture en_q=ch_en, clear fin and err, and set addr=0.
  - process=0: go to LOAD with ch_ptr = lowest set bit of ch_en.
  - process=1: go to RUN.
  - int_req with ch_en=0 is ignored. ready/eob are ignored.
- LOAD accept condition: ready=1 and next=0.
  - Register data into out_data, addr into out_addr, and onehot(ch_ptr) into out_we.
  - next=1 on the following cycle.
  - The next register therefore blocks back-to-back double accepts. Max rate is one word per 2 cycles.
- Normal accept (no eob): addr increments.
- Accept with eob=1: addr clears to 0 and ch_ptr moves to the next higher set bit of en_q. If no higher bit is set, go to RUN.
- Overflow: addr = 2^CNT_W-1 was already written and another non-eob word arrives.
  - The word is accepted (next pulses) but dropped: out_we=0.
  - err is set; addr holds.
  - On the eob word: the word is dropped, and ch_ptr advances as normal.
- RUN: start[c] = en_q[c] & ~fin[c] & (state==RUN). Driven from registers only.
  - done[c] sets fin[c]. done on a disabled or already-finished channel is ignored.
  - When fin == en_q, go to IDLE.
  - int_req, ready and eob are ignored in RUN.
- err stays high through RUN and IDLE until the next accepted session start.
- Reset (async, any state) clears: state=IDLE, next=0, out_we=0, out_data=0, out_addr=0, start=0, busy=0, err=0, en_q=0, fin=0, ch_ptr=0.

## Timing

- Session start: int_req sampled at edge t. busy=1 and the new state take effect after t.
- Accept: ready=1 sampled at edge t. next, out_data, out_addr and out_we are valid for exactly the cycle after t.
- Host protocol: the host may change data or drop ready in the cycle after next=1.
- Last eob accept at edge t: state=RUN after t. start is high in the same cycle as the final next pulse.
- done[c] sampled at edge t: start[c]=0 after t.
- Final done at edge t: busy=0 and start=0 after t.
- Reset assertion forces all outputs to reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan

- CH=4, CNT_W=2, ch_en=4'b1111, process=0; 2 words per channel, eob on each 2nd word -> out_we sequence 0001,0001,0010,0010,0100,0100,1000,1000. out_addr alternates 0,1. start=4'b1111 with the last next pulse. done pulses on 0,1,2,3 -> busy=0 one cycle after the last done.
- Skip mask: ch_en=4'b1010, 1 word per channel with eob -> out_we 0010 then 1000. start=4'b1010. done[0] pulse -> ignored, start still 4'b1010.
- Overflow: CNT_W=2, 6 words to channel 0 with eob on the 6th -> 4 writes at addr 0..3. Words 5,6 are dropped with next still pulsing. err=1 and remains 1 until the next session start.
- Handshake hold: ready held high for 5 cycles on one word, eob=0 -> exactly 3 accepts (cycles 1,3,5), next alternating 0/1, addr 0,1,2.
- process=1, ch_en=4'b0110 -> RUN immediately with no next pulses. start=4'b0110. done[1] and done[2] in the same cycle -> IDLE next cycle.
- Reset mid-LOAD after 3 words, then int_req with ch_en=0 -> all outputs 0 and block remains IDLE (busy=0).
